// File: rtl/axi_master_pkg.sv
// Shared types and constants for the AXI4 burst master.
// The perf counter option is enabled by defining AXI_MASTER_PERF_CNT_EN.
package axi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WADDR = 3'd3,
        ST_WDATA = 3'd4,
        ST_WRESP = 3'd5
    } state_e;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // One-cycle event strobes feeding the optional perf counters.
    typedef struct packed {
        logic rd_beat;
        logic wr_beat;
        logic stall;
    } perf_evt_t;

    // AxSIZE encoding: log2 of the bytes per beat.
    function automatic logic [2:0] size_of(input int data_w);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 8; i++)
            if ((8 << i) == data_w) s = 3'(i);
        return s;
    endfunction

endpackage

// File: rtl/axi_master_perf.sv
// Saturating beat/stall counters for axi_burst_master.
// Only elaborated when AXI_MASTER_PERF_CNT_EN is defined.
`ifdef AXI_MASTER_PERF_CNT_EN
module axi_master_perf
    import axi_master_pkg::*;
(
    input  logic        ACLK,
    input  logic        ARESETn,
    input  perf_evt_t   evt,
    output logic [31:0] perf_rd_beats,
    output logic [31:0] perf_wr_beats,
    output logic [31:0] perf_stall
);

    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            perf_rd_beats <= '0;
            perf_wr_beats <= '0;
            perf_stall    <= '0;
        end else begin
            if (evt.rd_beat && perf_rd_beats != '1) perf_rd_beats <= perf_rd_beats + 32'd1;
            if (evt.wr_beat && perf_wr_beats != '1) perf_wr_beats <= perf_wr_beats + 32'd1;
            if (evt.stall   && perf_stall    != '1) perf_stall    <= perf_stall    + 32'd1;
        end
    end

endmodule
`endif

// File: rtl/axi_burst_master.sv
// AXI4 INCR burst master: request/stream side to a single AXI master port.
// Define AXI_MASTER_PERF_CNT_EN to add the perf_* counter outputs.
module axi_burst_master
    import axi_master_pkg::*;
#(
    parameter int C_ID   = 0,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [LEN_W-1:0]      req_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_strb,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_last,
    output logic                  done,
    output logic                  err,
    output logic [ID_W-1:0]       M_AWID,
    output logic [ADDR_W-1:0]     M_AWADDR,
    output logic [LEN_W-1:0]      M_AWLEN,
    output logic [2:0]            M_AWSIZE,
    output logic [1:0]            M_AWBURST,
    output logic                  M_AWVALID,
    input  logic                  M_AWREADY,
    output logic [DATA_W-1:0]     M_WDATA,
    output logic [DATA_W/8-1:0]   M_WSTRB,
    output logic                  M_WLAST,
    output logic                  M_WVALID,
    input  logic                  M_WREADY,
    input  logic [ID_W-1:0]       M_BID,
    input  logic [1:0]            M_BRESP,
    input  logic                  M_BVALID,
    output logic                  M_BREADY,
    output logic [ID_W-1:0]       M_ARID,
    output logic [ADDR_W-1:0]     M_ARADDR,
    output logic [LEN_W-1:0]      M_ARLEN,
    output logic [2:0]            M_ARSIZE,
    output logic [1:0]            M_ARBURST,
    output logic                  M_ARVALID,
    input  logic                  M_ARREADY,
    input  logic [ID_W-1:0]       M_RID,
    input  logic [DATA_W-1:0]     M_RDATA,
    input  logic [1:0]            M_RRESP,
    input  logic                  M_RLAST,
    input  logic                  M_RVALID,
    output logic                  M_RREADY
`ifdef AXI_MASTER_PERF_CNT_EN
    ,
    output logic [31:0]           perf_rd_beats,
    output logic [31:0]           perf_wr_beats,
    output logic [31:0]           perf_stall
`endif
);

    localparam logic [2:0]      AX_SIZE = size_of(DATA_W);
    localparam logic [ID_W-1:0] MY_ID   = ID_W'(C_ID);

    state_e            state;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt;
    logic              err_q;

    logic last_beat, w_hs, r_hs, b_err, r_err, r_end, r_mismatch;

    assign last_beat  = (cnt == len_q);
    assign w_hs       = M_WVALID & M_WREADY;
    assign r_hs       = M_RVALID & M_RREADY;
    assign b_err      = (M_BRESP != RESP_OKAY) | (M_BID != MY_ID);
    assign r_err      = (M_RRESP != RESP_OKAY) | (M_RID != MY_ID);
    assign r_end      = M_RLAST | last_beat;
    assign r_mismatch = M_RLAST ^ last_beat;

    // The reset term keeps req_ready low while reset is held even though state is IDLE.
    assign req_ready = (state == ST_IDLE) & ~ARESETn;

    assign M_AWID    = MY_ID;
    assign M_AWADDR  = addr_q;
    assign M_AWLEN   = len_q;
    assign M_AWSIZE  = AX_SIZE;
    assign M_AWBURST = BURST_INCR;
    assign M_ARID    = MY_ID;
    assign M_ARADDR  = addr_q;
    assign M_ARLEN   = len_q;
    assign M_ARSIZE  = AX_SIZE;
    assign M_ARBURST = BURST_INCR;

    // Data channels are straight pass-throughs, gated by the owning state.
    assign M_WVALID = (state == ST_WDATA) & wr_valid;
    assign wr_ready = (state == ST_WDATA) & M_WREADY;
    assign M_WDATA  = wr_data;
    assign M_WSTRB  = wr_strb;
    assign M_WLAST  = last_beat;
    assign M_BREADY = (state == ST_WRESP);
    assign rd_valid = (state == ST_RDATA) & M_RVALID;
    assign M_RREADY = (state == ST_RDATA) & rd_ready;
    assign rd_data  = M_RDATA;
    assign rd_last  = last_beat;

    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            cnt       <= '0;
            err_q     <= 1'b0;
            M_AWVALID <= 1'b0;
            M_ARVALID <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        len_q  <= req_len;
                        cnt    <= '0;
                        err_q  <= 1'b0;
                        if (req_write) begin
                            state     <= ST_WADDR;
                            M_AWVALID <= 1'b1;
                        end else begin
                            state     <= ST_RADDR;
                            M_ARVALID <= 1'b1;
                        end
                    end
                end
                ST_WADDR: begin
                    if (M_AWREADY) begin
                        M_AWVALID <= 1'b0;
                        state     <= ST_WDATA;
                    end
                end
                ST_RADDR: begin
                    if (M_ARREADY) begin
                        M_ARVALID <= 1'b0;
                        state     <= ST_RDATA;
                    end
                end
                ST_WDATA: begin
                    if (w_hs) begin
                        if (last_beat) state <= ST_WRESP;
                        else           cnt   <= cnt + LEN_W'(1);
                    end
                end
                ST_WRESP: begin
                    if (M_BVALID) begin
                        err_q <= err_q | b_err;
                        err   <= err_q | b_err;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                ST_RDATA: begin
                    if (r_hs) begin
                        // Early RLAST or a missing RLAST both end the burst but flag an error.
                        err_q <= err_q | r_err | (r_end & r_mismatch);
                        if (r_end) begin
                            err   <= err_q | r_err | r_mismatch;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            cnt <= cnt + LEN_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef AXI_MASTER_PERF_CNT_EN
    perf_evt_t perf_evt;

    assign perf_evt.rd_beat = r_hs;
    assign perf_evt.wr_beat = w_hs;
    assign perf_evt.stall   = (M_AWVALID & ~M_AWREADY) | (M_ARVALID & ~M_ARREADY)
                            | (M_WVALID & ~M_WREADY) | (M_RREADY & ~M_RVALID);

    axi_master_perf u_perf (
        .ACLK          (ACLK),
        .ARESETn       (ARESETn),
        .evt           (perf_evt),
        .perf_rd_beats (perf_rd_beats),
        .perf_wr_beats (perf_wr_beats),
        .perf_stall    (perf_stall)
    );
`endif

endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- Parametrised AXI4 master bridging a CPU/DMA-side request interface to one AXI master port.
- Supports variable-length INCR read and write bursts of up to 2^LEN_W beats, with streamed valid/ready data in both directions.
- Reports completion and an error summary per transaction.
- Sits between a core's memory port and the AXI interconnect; the next generation of the fixed-length master wrapper.

Parameters:
- C_ID, 0, value driven on AWID/ARID.
- ID_W, 4, AXI ID width.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; power of two, minimum 8.
- LEN_W, 4, AxLEN width; maximum burst is 2^LEN_W beats.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous reset, active-high (asserted = 1).
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  start address, DATA_W/8-aligned.
- req_len  in  LEN_W  beats-1.
- wr_valid / wr_ready  in/out  1  CPU write-data stream handshake.
- wr_data  in  DATA_W  write data.
- wr_strb  in  DATA_W/8  byte enables, 1 = write byte.
- rd_valid / rd_ready  out/in  1  read-data stream handshake.
- rd_data  out  DATA_W  read data.
- rd_last  out  1  last read beat.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = any non-OKAY response or protocol mismatch.
- M_AW*: AWID(ID_W), AWADDR(ADDR_W), AWLEN(LEN_W), AWSIZE(3), AWBURST(2), AWVALID out; AWREADY in.
- M_W*: WDATA, WSTRB, WLAST, WVALID out; WREADY in.
- M_B*: BID(ID_W), BRESP(2), BVALID in; BREADY out.
- M_AR*: same set as AW, with AR prefix.
- M_R*: RID, RDATA, RRESP(2), RLAST, RVALID in; RREADY out.

Behaviour:
- States: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP.
- Reset: state IDLE; all VALID/READY outputs 0; done=0, err=0; latched addr, len, count and sticky error cleared.
- Reset mid-burst aborts immediately with no completion pulse.
- IDLE: req_ready=1. On req_valid, latch addr/len/write, clear the beat counter and sticky error, then go to WADDR if write, else RADDR. No request is accepted outside IDLE.
- Address channel:
  - AxVALID=1 held from the state's first cycle until AxREADY.
  - Address fields are stable while valid.
  - AxSIZE = log2(DATA_W/8); AxBURST = INCR (2'b01).
  - Handshake moves the FSM to RDATA or WDATA.
- WDATA:
  - Combinational pass-through: M_WVALID = wr_valid; wr_ready = M_WREADY.
  - WLAST = (cnt == len_q). cnt increments on each W handshake.
  - The handshake with WLAST moves to WRESP.
  - WSTRB = wr_strb; WDATA = wr_data.
- WRESP: BREADY=1. On BVALID, sticky error |= (BRESP != OKAY) | (BID != C_ID); then done=1 for one cycle and return to IDLE.
- RDATA:
  - Combinational pass-through: rd_valid = M_RVALID; M_RREADY = rd_ready.
  - rd_data = RDATA; rd_last = (cnt == len_q).
  - Per handshake: sticky error |= (RRESP != OKAY) | (RID != C_ID).
  - Burst ends on the handshake where RLAST=1 or cnt==len_q, whichever comes first. Error is also set if the two disagree.
  - On burst end: done pulse, return to IDLE.
- Latency:
  - done is asserted in the cycle after the final B or R handshake.
  - The next request can be accepted in that same cycle.
  - No combinational path from req_* to M_* outputs.
- len=0: single beat; WLAST and rd_last are set on the first beat.
- len = 2^LEN_W-1: counter reaches its maximum without wrap; cnt width is LEN_W.
- Crossing a 4 KB boundary is the requester's responsibility; the block does not split bursts.
- Simultaneous done and req_valid: request accepted (state is IDLE in the done cycle).

Optional Feature:
- Macro AXI_MASTER_PERF_CNT_EN.
- Defined:
  - Adds output perf_rd_beats (32), perf_wr_beats (32) and perf_stall (32).
  - perf_stall counts cycles with AxVALID&!AxREADY, WVALID&!WREADY or RREADY&!RVALID.
  - Counters are saturating and reset to 0.
- Undefined: ports and counters are absent, with identical functional behaviour.

Decomposition:
- Package axi_master_pkg:
  - state enum (3-bit);
  - BURST_INCR=2'b01;
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - function size_of(DATA_W).
- One sub-module axi_master_perf, instantiated only under AXI_MASTER_PERF_CNT_EN.

Test Plan:
- Read, len=3, addr 0x1000, slave returns 0xA0..0xA3 OKAY, rd_ready always 1 → ARLEN=3, ARSIZE=2, four rd beats, rd_last on 0xA3, done=1, err=0.
- Write, len=0, addr 0x2004, data 0xDEADBEEF, strb 4'b0011 → AWLEN=0, one beat with WLAST=1 and WSTRB=0011; BRESP=OKAY → done, err=0.
- Write, len=15, slave WREADY toggling and AWREADY delayed 5 cycles → exactly 16 W beats with WLAST only on the 16th; BRESP=SLVERR → err=1.
- Read, len=7, slave asserts RLAST on beat 4 → burst ends after 4 beats, done, err=1; a back-to-back request in the done cycle is accepted.
- Reset asserted during WDATA beat 2 → all valids 0 and state IDLE asynchronously; after release, req_ready=1 and no done pulse.
- PERF_CNT_EN build, read len=3 with 2 stall cycles → perf_rd_beats=4, perf_stall=2.
